// File: rtl/coproc_defs_pkg.sv
// Shared definitions for the coprocessor multipliers: FSM encoding, result
// width rule and flat-packing index helpers.
package coproc_defs;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIM  = 2'd2
    } estado_t;

    // Guard bits cover the sum of N<=8 full-scale products without overflow.
    function automatic int largura_resultado(input int largura);
        return 2 * largura + 3;
    endfunction

    function automatic int largura_indice(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // LSB position of element number idx in a flat vector of w-bit elements.
    function automatic int lsb_elemento(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/controle_multiplicacao_seq_mac_elemento.sv
// Combinational signed multiply-accumulate step: soma = acc + a*b, all in
// RW-bit wrap-around arithmetic. The accumulator register lives in the caller.
module mac_elemento #(
    parameter int WIDTH = 8,
    parameter int RW    = 2 * WIDTH + 3
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [RW-1:0]    acc,
    output logic [RW-1:0]    soma
);

    logic signed [RW-1:0] a_ext;
    logic signed [RW-1:0] b_ext;
    logic signed [RW-1:0] produto;

    // Extend before multiplying so the product keeps its sign at RW bits.
    assign a_ext   = {{(RW - WIDTH){a[WIDTH-1]}}, a};
    assign b_ext   = {{(RW - WIDTH){b[WIDTH-1]}}, b};
    assign produto = a_ext * b_ext;
    assign soma    = acc + produto;

endmodule

// File: rtl/controle_multiplicacao_seq.sv
// Sequential N x N matrix multiplier: one shared MAC stepped through every
// (i,j,k) term by a small scheduler FSM. Same flat packing as the parallel unit.
module controle_multiplicacao_seq
    import coproc_defs::*;
#(
    parameter  int N     = 3,
    parameter  int WIDTH = 8,
    localparam int RW    = largura_resultado(WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  cancelar,
    input  logic [N*N*WIDTH-1:0]  A,
    input  logic [N*N*WIDTH-1:0]  B,
    output logic                  busy,
    output logic                  done,
    output logic [N*N*RW-1:0]     Resultado
);

    localparam int NE = N * N;
    localparam int IW = largura_indice(N);
    localparam int EW = largura_indice(NE);

    estado_t          estado_reg;
    logic [IW-1:0]    i_reg;
    logic [IW-1:0]    j_reg;
    logic [IW-1:0]    k_reg;
    logic [RW-1:0]    acc_reg;
    logic [WIDTH-1:0] a_reg   [NE];
    logic [WIDTH-1:0] b_reg   [NE];
    logic [RW-1:0]    buf_reg [NE];

    logic [WIDTH-1:0] a_in [NE];
    logic [WIDTH-1:0] b_in [NE];
    logic [RW-1:0]    resultado_next [NE];

    logic [EW-1:0]    a_idx;
    logic [EW-1:0]    b_idx;
    logic [EW-1:0]    r_idx;
    logic [RW-1:0]    acc_next;
    logic             ultimo_k;
    logic             ultimo_j;
    logic             ultimo_i;

    // Unpack the flat operand ports into element arrays.
    genvar gi;
    generate
        for (gi = 0; gi < NE; gi++) begin : g_desempacota
            assign a_in[gi] = A[lsb_elemento(gi, WIDTH) +: WIDTH];
            assign b_in[gi] = B[lsb_elemento(gi, WIDTH) +: WIDTH];
        end
    endgenerate

    assign a_idx    = EW'(i_reg) * EW'(N) + EW'(k_reg);
    assign b_idx    = EW'(k_reg) * EW'(N) + EW'(j_reg);
    assign r_idx    = EW'(i_reg) * EW'(N) + EW'(j_reg);
    assign ultimo_k = (k_reg == IW'(N - 1));
    assign ultimo_j = (j_reg == IW'(N - 1));
    assign ultimo_i = (i_reg == IW'(N - 1));

    mac_elemento #(
        .WIDTH (WIDTH),
        .RW    (RW)
    ) u_mac (
        .a    (a_reg[a_idx]),
        .b    (b_reg[b_idx]),
        .acc  (acc_reg),
        .soma (acc_next)
    );

    // Final snapshot: the last element is still in flight on the final term,
    // so it comes straight from the MAC rather than the buffer.
    generate
        for (gi = 0; gi < NE; gi++) begin : g_final
            if (gi == NE - 1) begin : g_ultimo
                assign resultado_next[gi] = acc_next;
            end else begin : g_buffer
                assign resultado_next[gi] = buf_reg[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_reg <= IDLE;
            i_reg      <= '0;
            j_reg      <= '0;
            k_reg      <= '0;
            acc_reg    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            Resultado  <= '0;
            for (int e = 0; e < NE; e++) begin
                a_reg[e]   <= '0;
                b_reg[e]   <= '0;
                buf_reg[e] <= '0;
            end
        end else begin
            case (estado_reg)
                IDLE: begin
                    done <= 1'b0;
                    // start beats cancelar here: cancelar is only meaningful in CALC.
                    if (start) begin
                        for (int e = 0; e < NE; e++) begin
                            a_reg[e] <= a_in[e];
                            b_reg[e] <= b_in[e];
                        end
                        i_reg      <= '0;
                        j_reg      <= '0;
                        k_reg      <= '0;
                        acc_reg    <= '0;
                        busy       <= 1'b1;
                        estado_reg <= CALC;
                    end
                end

                CALC: begin
                    if (cancelar) begin
                        i_reg      <= '0;
                        j_reg      <= '0;
                        k_reg      <= '0;
                        acc_reg    <= '0;
                        busy       <= 1'b0;
                        estado_reg <= IDLE;
                    end else if (!ultimo_k) begin
                        acc_reg <= acc_next;
                        k_reg   <= k_reg + IW'(1);
                    end else begin
                        buf_reg[r_idx] <= acc_next;
                        acc_reg        <= '0;
                        k_reg          <= '0;
                        if (!ultimo_j) begin
                            j_reg <= j_reg + IW'(1);
                        end else begin
                            j_reg <= '0;
                            if (!ultimo_i) begin
                                i_reg <= i_reg + IW'(1);
                            end else begin
                                i_reg <= '0;
                                for (int e = 0; e < NE; e++) begin
                                    Resultado[lsb_elemento(e, RW) +: RW] <= resultado_next[e];
                                end
                                busy       <= 1'b0;
                                done       <= 1'b1;
                                estado_reg <= FIM;
                            end
                        end
                    end
                end

                FIM: begin
                    done       <= 1'b0;
                    estado_reg <= IDLE;
                end

                default: begin
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    estado_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controle_multiplicacao_seq.sv
// Randomized self-checking bench for controle_multiplicacao_seq against a
// plain-arithmetic matrix product model.
module tb_controle_multiplicacao_seq;

    localparam int N    = 3;
    localparam int W    = 8;
    localparam int RW   = 2 * W + 3;
    localparam int TOT  = N * N * W;
    localparam int RTOT = N * N * RW;
    localparam int LAT  = N * N * N;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            cancelar = 1'b0;
    logic [TOT-1:0]  A = '0;
    logic [TOT-1:0]  B = '0;
    logic            busy;
    logic            done;
    logic [RTOT-1:0] Resultado;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [RTOT-1:0] res_esperado = '0;

    controle_multiplicacao_seq #(.N(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cancelar  (cancelar),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .done      (done),
        .Resultado (Resultado)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [RTOT-1:0] modelo(input logic [TOT-1:0] a, input logic [TOT-1:0] b);
        logic [RTOT-1:0] r;
        logic [W-1:0]    ea;
        logic [W-1:0]    eb;
        int              s;
        r = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                s = 0;
                for (int k = 0; k < N; k++) begin
                    ea = a[(i*N+k)*W +: W];
                    eb = b[(k*N+j)*W +: W];
                    s += int'($signed(ea)) * int'($signed(eb));
                end
                r[(i*N+j)*RW +: RW] = RW'(s);
            end
        end
        return r;
    endfunction

    function automatic logic [TOT-1:0] aleatorio();
        logic [TOT-1:0] v;
        for (int e = 0; e < N*N; e++) v[e*W +: W] = W'($urandom);
        return v;
    endfunction

    // Counts busy samples after the start edge (bounded), then samples done.
    task automatic espera_fim(output int nbusy, output logic viu_done);
        nbusy = 0;
        for (int c = 0; c < 200 && busy === 1'b1; c++) begin
            nbusy++;
            tick();
        end
        viu_done = done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags busy=%b done=%b exp 0 0", busy, done);
        end
        checks++;
        if (Resultado !== '0) begin
            errors++;
            $display("FAIL reset_resultado got %h exp 0", Resultado);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_identity();
        int nb;
        logic d;
        logic [RTOT-1:0] esp;
        A = '0;
        B = '0;
        esp = '0;
        for (int e = 0; e < N*N; e++) begin
            B[e*W +: W] = W'(e + 1);
            esp[e*RW +: RW] = RW'(e + 1);
        end
        for (int i = 0; i < N; i++) A[(i*N+i)*W +: W] = 8'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        espera_fim(nb, d);
        checks++;
        if (nb !== LAT) begin
            errors++;
            $display("FAIL identity_latency got %0d exp %0d", nb, LAT);
        end
        checks++;
        if (d !== 1'b1) begin
            errors++;
            $display("FAIL identity_done got %b exp 1", d);
        end
        checks++;
        if (Resultado !== esp) begin
            errors++;
            $display("FAIL identity_result got %h exp %h", Resultado, esp);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL identity_done_pulse got %b exp 0", done);
        end
        res_esperado = esp;
        $display("test_identity result=%h", Resultado);
    endtask

    task automatic roda_extremo(input logic [W-1:0] va, input logic [W-1:0] vb, input int valor, input string nome);
        int nb;
        logic d;
        logic [RTOT-1:0] esp;
        for (int e = 0; e < N*N; e++) begin
            A[e*W +: W] = va;
            B[e*W +: W] = vb;
            esp[e*RW +: RW] = RW'(valor);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        espera_fim(nb, d);
        checks++;
        if (d !== 1'b1 || Resultado !== esp) begin
            errors++;
            $display("FAIL %s done=%b got %h exp %h", nome, d, Resultado, esp);
        end
        tick();
        res_esperado = esp;
        $display("%s elem0=%0d", nome, $signed(Resultado[RW-1:0]));
    endtask

    task automatic test_extremes();
        roda_extremo(8'h80, 8'h80, 49152, "extreme_neg_neg");
        roda_extremo(8'h7f, 8'h80, -48768, "extreme_pos_neg");
    endtask

    task automatic test_random();
        int nb;
        logic d;
        logic [RTOT-1:0] esp;
        for (int r = 0; r < 4; r++) begin
            A = aleatorio();
            B = aleatorio();
            esp = modelo(A, B);
            start = 1'b1;
            tick();
            start = 1'b0;
            espera_fim(nb, d);
            checks++;
            if (nb !== LAT || d !== 1'b1 || Resultado !== esp) begin
                errors++;
                $display("FAIL random_%0d busy=%0d done=%b got %h exp %h", r, nb, d, Resultado, esp);
            end
            tick();
            res_esperado = esp;
            $display("test_random run %0d result=%h", r, Resultado);
        end
    endtask

    task automatic test_ignore_hold();
        int nb;
        logic [RTOT-1:0] esp;
        A = aleatorio();
        B = aleatorio();
        esp = modelo(A, B);
        start = 1'b1;
        tick();
        start = 1'b0;
        nb = 0;
        for (int c = 0; c < 200 && busy === 1'b1; c++) begin
            nb++;
            if (nb == 10) begin
                start = 1'b1;
                A = aleatorio();
                B = aleatorio();
            end else begin
                start = 1'b0;
            end
            if (nb == 5 || nb == 20) begin
                checks++;
                if (Resultado !== res_esperado) begin
                    errors++;
                    $display("FAIL hold_cycle%0d got %h exp %h", nb, Resultado, res_esperado);
                end
            end
            tick();
        end
        start = 1'b0;
        checks++;
        if (nb !== LAT || done !== 1'b1) begin
            errors++;
            $display("FAIL ignore_latency busy=%0d done=%b exp %0d 1", nb, done, LAT);
        end
        checks++;
        if (Resultado !== esp) begin
            errors++;
            $display("FAIL ignore_captured got %h exp %h", Resultado, esp);
        end
        tick();
        res_esperado = esp;
        $display("test_ignore_hold result=%h", Resultado);
    endtask

    task automatic test_cancel();
        int nb;
        logic d;
        logic [RTOT-1:0] esp;
        A = aleatorio();
        B = aleatorio();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 15; c++) tick();
        cancelar = 1'b1;
        tick();
        cancelar = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL cancel_flags busy=%b done=%b exp 0 0", busy, done);
        end
        for (int c = 0; c < 30; c++) begin
            tick();
            if (done !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL cancel_no_done got 1 exp 0 at cycle %0d", cyc);
                break;
            end
        end
        checks++;
        if (Resultado !== res_esperado) begin
            errors++;
            $display("FAIL cancel_hold got %h exp %h", Resultado, res_esperado);
        end
        A = aleatorio();
        B = aleatorio();
        esp = modelo(A, B);
        start = 1'b1;
        tick();
        start = 1'b0;
        espera_fim(nb, d);
        checks++;
        if (nb !== LAT || d !== 1'b1 || Resultado !== esp) begin
            errors++;
            $display("FAIL cancel_rerun busy=%0d done=%b got %h exp %h", nb, d, Resultado, esp);
        end
        tick();
        res_esperado = esp;
        $display("test_cancel rerun result=%h", Resultado);
    endtask

    task automatic test_async_reset();
        int nb;
        logic d;
        logic [RTOT-1:0] esp;
        A = aleatorio();
        B = aleatorio();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 12; c++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || Resultado !== '0) begin
            errors++;
            $display("FAIL async_reset busy=%b done=%b got %h exp 0", busy, done, Resultado);
        end
        res_esperado = '0;
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || Resultado !== '0) begin
            errors++;
            $display("FAIL post_reset_idle busy=%b got %h exp 0", busy, Resultado);
        end
        esp = modelo(A, B);
        start = 1'b1;
        tick();
        start = 1'b0;
        espera_fim(nb, d);
        checks++;
        if (nb !== LAT || d !== 1'b1 || Resultado !== esp) begin
            errors++;
            $display("FAIL reset_rerun busy=%0d done=%b got %h exp %h", nb, d, Resultado, esp);
        end
        tick();
        res_esperado = esp;
        $display("test_async_reset rerun result=%h", Resultado);
    endtask

    task automatic test_back_to_back();
        logic [RTOT-1:0] esp;
        int ndone;
        int t_ant;
        A = aleatorio();
        B = aleatorio();
        esp = modelo(A, B);
        ndone = 0;
        t_ant = 0;
        start = 1'b1;
        for (int c = 0; c < 150 && ndone < 3; c++) begin
            tick();
            if (done === 1'b1) begin
                ndone++;
                checks++;
                if (Resultado !== esp) begin
                    errors++;
                    $display("FAIL b2b_result_%0d got %h exp %h", ndone, Resultado, esp);
                end
                if (ndone > 1) begin
                    checks++;
                    if (cyc - t_ant !== LAT + 2) begin
                        errors++;
                        $display("FAIL b2b_spacing_%0d got %0d exp %0d", ndone, cyc - t_ant, LAT + 2);
                    end
                end
                $display("back_to_back done %0d at cycle %0d", ndone, cyc);
                t_ant = cyc;
                // New operands are in place before the next capture edge.
                A = aleatorio();
                B = aleatorio();
                esp = modelo(A, B);
                if (ndone == 3) start = 1'b0;
            end
        end
        start = 1'b0;
        checks++;
        if (ndone !== 3) begin
            errors++;
            $display("FAIL b2b_count got %0d exp 3", ndone);
        end
        tick();
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stop busy=%b exp 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_extremes();
        test_random();
        test_ignore_hold();
        test_cancel();
        test_async_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/controle_multiplicacao_seq.md
Name: controle_multiplicacao_seq

Overview:
Sequential, resource-shared matrix multiply engine for the coprocessor. It replaces the fully parallel N*N*N-multiplier array with one signed multiply-accumulate unit. An i/j/k scheduler FSM steps that unit through every product term. It uses the same flat operand/result packing as the combinational multiplier, so the coprocessor top level can select either implementation.

Parameters:
N, 3, matrix dimension (N x N operands).
WIDTH, 8, signed element width of A and B.
RW, 2*WIDTH+3, localparam (not overridable): result element width.

Ports:
clk  input  1  single system clock; all state changes on its rising edge.
rst_n  input  1  reset, asynchronous and active-low.
start  input  1  request to begin one multiplication; honoured only in IDLE.
cancelar  input  1  synchronous abort of a running multiplication.
A  input  N*N*WIDTH  signed operand; element (i,k) at bits [((i*N+k)*WIDTH) +: WIDTH].
B  input  N*N*WIDTH  signed operand; element (k,j) at bits [((k*N+j)*WIDTH) +: WIDTH].
busy  output  1  high while the multiplication is running.
done  output  1  one-cycle pulse when Resultado has been updated.
Resultado  output  N*N*RW  signed product; element (i,j) at bits [((i*N+j)*RW) +: RW].

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset (any state, including mid-operation):
  - FSM goes to IDLE.
  - i, j, k and the accumulator are cleared.
  - busy=0, done=0, Resultado=0.
  - Internal operand copies and the result buffer are cleared.
- FSM states: IDLE, CALC, FIM.
- IDLE:
  - On a rising edge with start=1, capture A and B into internal registers.
  - Clear i=j=k=0 and acc=0, then go to CALC.
  - A and B are ignored after capture.
- CALC: each cycle, acc_next = acc + sext(A[i][k]) * sext(B[k][j]), computed in RW-bit signed arithmetic.
  - k<N-1: acc<=acc_next and k<=k+1.
  - k==N-1: write acc_next to result buffer element (i,j). Then acc<=0, k<=0, and (i,j) advances row-major (j first, then i).
  - After the term (N-1,N-1,N-1): copy the whole result buffer to Resultado in the same edge, then go to FIM.
- FIM: done=1 for exactly one cycle, then IDLE unconditionally.
- Timing:
  - CALC lasts exactly N^3 cycles.
  - With start sampled at edge E0: busy=1 from E0 to E(N^3), and done=1 from E(N^3) to E(N^3+1).
  - For N=3: 27 busy cycles, done in cycle 28.
- busy equals (state==CALC). done equals (state==FIM). Both outputs are registered.
- Resultado changes only on the CALC-to-FIM edge (all elements at once). Otherwise it holds its previous value, including during computation and after a cancel.
- Width rule: products and sums wrap modulo 2^RW. This is overflow-free for N<=8.
- start while busy or in FIM: ignored, not queued.
- start held high continuously: a new run begins on the edge after FIM. Back-to-back period is N^3+2 cycles.
- cancelar=1 in CALC: go to IDLE on the next edge, with no done pulse and Resultado unchanged. cancelar has priority over completing the last term.
- cancelar in IDLE or FIM: no effect. If cancelar and start are both high in IDLE, start wins.

Decomposition:
- Shared package/include coproc_defs: FSM state encodings (IDLE/CALC/FIM), RW width expression, and element-index helper macros for flat packing.
- One sub-module, mac_elemento: signed WIDTH x WIDTH multiplier with an RW-bit adder. It is combinational; the accumulator register stays in the controller.

Test Plan:
- Identity: A=I, B elements 1..9 -> after 27 busy cycles, done pulses once in cycle 28 and Resultado elements are 1..9.
- Extremes: all A=-128, all B=-128 -> every element 49152. With A=127 and B=-128 everywhere -> every element -48768, with no sign loss.
- Ignore and hold: start pulsed again at cycle 10 of a run, and A/B changed mid-run -> no restart, result uses the captured operands, and Resultado holds the old value until done.
- Cancel: cancelar at cycle 15 -> busy low next cycle, no done, Resultado keeps the previous run's value. A following start gives the correct result.
- Reset: rst_n low at cycle 12 -> busy, done and Resultado all 0 immediately (asynchronous). After release, the module is in IDLE.
- Back-to-back: start held high for three runs -> done pulses spaced exactly 29 cycles apart, with correct results each time.
